// File: rtl/block_sync_pkg.sv
// Shared PCS definitions: sync header encodings, block-sync FSM states and
// the descrambler payload width.
package block_sync_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam int DESCR_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        TEST_SH = 2'd0,
        SLIP    = 2'd1,
        HOLDOFF = 2'd2
    } sync_state_t;

    function automatic logic isValidHeader(input logic [1:0] hdr);
        return (hdr == SH_DATA) || (hdr == SH_CTRL);
    endfunction

endpackage

// File: rtl/block_sync.sv
// 66b block synchroniser: hunts for sync-header alignment by requesting gearbox
// slips, declares block lock, and forwards locked blocks to the descrambler.
module block_sync
    import block_sync_pkg::*;
#(
    parameter int PCS_DATA_WIDTH = DESCR_DATA_WIDTH,
    parameter int SH_GOOD_CNT    = 64,
    parameter int SH_BAD_MAX     = 16,
    parameter int SLIP_HOLDOFF   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [1:0]                in_header,
    input  logic [PCS_DATA_WIDTH-1:0] in_data,
    input  logic                      in_data_valid,
    output logic [1:0]                out_header,
    output logic [PCS_DATA_WIDTH-1:0] out_data,
    output logic                      out_data_valid,
    output logic                      block_lock,
    output logic                      slip
);

    localparam int CNT_W  = $clog2(SH_GOOD_CNT) + 1;
    localparam int BAD_W  = $clog2(SH_BAD_MAX) + 1;
    localparam int HOLD_W = $clog2(SLIP_HOLDOFF) + 1;

    sync_state_t               r_state;
    logic [CNT_W-1:0]          r_shCnt;
    logic [BAD_W-1:0]          r_shBadCnt;
    logic [HOLD_W-1:0]         r_holdoffCnt;
    logic                      r_blockLock;
    logic                      r_outValid;
    logic [1:0]                r_outHeader;
    logic [PCS_DATA_WIDTH-1:0] r_outData;

    sync_state_t       w_stateNext;
    logic [CNT_W-1:0]  w_shCntNext;
    logic [BAD_W-1:0]  w_shBadNext;
    logic [HOLD_W-1:0] w_holdoffNext;
    logic              w_lockNext;
    logic              w_hdrValid;
    logic [CNT_W-1:0]  w_shCntInc;
    logic [BAD_W-1:0]  w_shBadInc;

    assign w_hdrValid = isValidHeader(in_header);
    assign w_shCntInc = r_shCnt + CNT_W'(1);
    assign w_shBadInc = r_shBadCnt + {{(BAD_W-1){1'b0}}, ~w_hdrValid};

    always_comb begin
        w_stateNext   = r_state;
        w_shCntNext   = r_shCnt;
        w_shBadNext   = r_shBadCnt;
        w_holdoffNext = r_holdoffCnt;
        w_lockNext    = r_blockLock;
        case (r_state)
            TEST_SH: begin
                if (in_data_valid) begin
                    if (!r_blockLock) begin
                        if (!w_hdrValid) begin
                            w_stateNext = SLIP;
                            w_shCntNext = '0;
                            w_shBadNext = '0;
                        end else if (w_shCntInc == CNT_W'(SH_GOOD_CNT)) begin
                            w_lockNext  = 1'b1;
                            w_shCntNext = '0;
                            w_shBadNext = '0;
                        end else begin
                            w_shCntNext = w_shCntInc;
                        end
                    // Losing lock beats window completion on the same block.
                    end else if (w_shBadInc == BAD_W'(SH_BAD_MAX)) begin
                        w_lockNext  = 1'b0;
                        w_stateNext = SLIP;
                        w_shCntNext = '0;
                        w_shBadNext = '0;
                    end else if (w_shCntInc == CNT_W'(SH_GOOD_CNT)) begin
                        w_shCntNext = '0;
                        w_shBadNext = '0;
                    end else begin
                        w_shCntNext = w_shCntInc;
                        w_shBadNext = w_shBadInc;
                    end
                end
            end
            SLIP: begin
                w_stateNext   = HOLDOFF;
                w_holdoffNext = HOLD_W'(SLIP_HOLDOFF);
            end
            HOLDOFF: begin
                if (in_data_valid) begin
                    if (r_holdoffCnt <= HOLD_W'(1)) begin
                        w_stateNext   = TEST_SH;
                        w_holdoffNext = '0;
                        w_shCntNext   = '0;
                        w_shBadNext   = '0;
                    end else begin
                        w_holdoffNext = r_holdoffCnt - HOLD_W'(1);
                    end
                end
            end
            default: begin
                w_stateNext = TEST_SH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= TEST_SH;
            r_shCnt      <= '0;
            r_shBadCnt   <= '0;
            r_holdoffCnt <= '0;
            r_blockLock  <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_shCnt      <= w_shCntNext;
            r_shBadCnt   <= w_shBadNext;
            r_holdoffCnt <= w_holdoffNext;
            r_blockLock  <= w_lockNext;
        end
    end

    // Forwarding uses the lock value from before this block's update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_outValid  <= 1'b0;
            r_outHeader <= 2'b00;
            r_outData   <= '0;
        end else begin
            r_outValid <= in_data_valid & r_blockLock;
            if (in_data_valid) begin
                r_outHeader <= in_header;
                r_outData   <= in_data;
            end
        end
    end

    assign out_header     = r_outHeader;
    assign out_data       = r_outData;
    assign out_data_valid = r_outValid;
    assign block_lock     = r_blockLock;
    assign slip           = (r_state == SLIP);

endmodule

// File: tb/tb_block_sync.sv
// Scoreboard bench for block_sync: a behavioural reference model predicts each
// cycle's outputs, which are queued on drive and compared after the edge.
module tb_block_sync;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  inHeader = 2'b00;
    logic [63:0] inData = '0;
    logic        inValid = 1'b0;
    logic [1:0]  outHeader;
    logic [63:0] outData;
    logic        outValid;
    logic        blockLock;
    logic        slip;

    int testsRun  = 0;
    int failCount = 0;
    int slipSeen  = 0;

    typedef struct {
        logic        lock;
        logic        slipExp;
        logic        ov;
        logic [1:0]  hdr;
        logic [63:0] data;
    } expect_t;

    expect_t scoreboard[$];

    // Reference model: 0 = testing headers, 1 = slipping, 2 = holding off
    int          mState = 0;
    int          mCnt = 0;
    int          mBad = 0;
    int          mHold = 0;
    bit          mLock = 0;
    bit          mOv = 0;
    logic [1:0]  mHdr = 2'b00;
    logic [63:0] mData = '0;

    always #5 clk = ~clk;

    block_sync dut (
        .clk            (clk),
        .rst            (rst),
        .in_header      (inHeader),
        .in_data        (inData),
        .in_data_valid  (inValid),
        .out_header     (outHeader),
        .out_data       (outData),
        .out_data_valid (outValid),
        .block_lock     (blockLock),
        .slip           (slip)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelStep(input bit rstn, input bit v, input logic [1:0] h, input logic [63:0] d);
        bit good;
        good = (h == 2'b01) || (h == 2'b10);
        if (!rstn) begin
            mState = 0; mCnt = 0; mBad = 0; mHold = 0;
            mLock = 0; mOv = 0; mHdr = 2'b00; mData = '0;
            return;
        end
        mOv = v && mLock;
        if (v) begin
            mHdr  = h;
            mData = d;
        end
        if (mState == 1) begin
            mState = 2;
            mHold  = 4;
        end else if (mState == 2) begin
            if (v) begin
                mHold--;
                if (mHold == 0) begin
                    mState = 0; mCnt = 0; mBad = 0;
                end
            end
        end else if (v) begin
            mCnt++;
            if (!good) mBad++;
            if (!mLock) begin
                if (!good) begin
                    mState = 1; mCnt = 0; mBad = 0;
                end else if (mCnt == 64) begin
                    mLock = 1; mCnt = 0; mBad = 0;
                end
            end else if (mBad == 16) begin
                mLock = 0; mState = 1; mCnt = 0; mBad = 0;
            end else if (mCnt == 64) begin
                mCnt = 0; mBad = 0;
            end
        end
    endtask

    task automatic applyStimulus(input bit rstn, input bit v, input logic [1:0] h, input logic [63:0] d);
        expect_t e;
        rst      = rstn;
        inValid  = v;
        inHeader = h;
        inData   = d;
        modelStep(rstn, v, h, d);
        e.lock = mLock; e.slipExp = (mState == 1); e.ov = mOv; e.hdr = mHdr; e.data = mData;
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
        if (scoreboard.size() == 0) begin
            checkOutput("scoreboardEmpty", 64'd1, 64'd0);
        end else begin
            e = scoreboard.pop_front();
            checkOutput("block_lock", {63'd0, blockLock}, {63'd0, e.lock});
            checkOutput("slip", {63'd0, slip}, {63'd0, e.slipExp});
            checkOutput("out_data_valid", {63'd0, outValid}, {63'd0, e.ov});
            checkOutput("out_header", {62'd0, outHeader}, {62'd0, e.hdr});
            checkOutput("out_data", outData, e.data);
        end
        if (slip) slipSeen++;
    endtask

    function automatic logic [1:0] goodHdr();
        return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [63:0] rndData();
        return {$urandom, $urandom};
    endfunction

    task automatic sendGood(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, goodHdr(), rndData());
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b1, 2'b11, rndData());
    endtask

    initial begin
        logic [63:0] d;
        doReset();
        doReset();
        checkOutput("rstLock", {63'd0, blockLock}, 64'd0);
        checkOutput("rstOutData", outData, 64'd0);

        // Clean lock acquisition; block 65 is the first forwarded
        sendGood(63);
        checkOutput("noLockAt63", {63'd0, blockLock}, 64'd0);
        sendGood(1);
        checkOutput("lockAt64", {63'd0, blockLock}, 64'd1);
        checkOutput("lockBlockNotFwd", {63'd0, outValid}, 64'd0);
        d = 64'hA5A5_0123_4567_89AB;
        applyStimulus(1'b1, 1'b1, 2'b01, d);
        checkOutput("blk65Valid", {63'd0, outValid}, 64'd1);
        checkOutput("blk65Data", outData, d);

        // Bad header on block 10 while hunting; holdoff blocks are ignored
        doReset();
        slipSeen = 0;
        sendGood(9);
        applyStimulus(1'b1, 1'b1, 2'b11, rndData());
        checkOutput("slipAfterBad", {63'd0, slip}, 64'd1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 2'b00, rndData());
        checkOutput("oneSlipPulse", slipSeen, 64'd1);
        sendGood(63);
        checkOutput("noLockAfterSlip63", {63'd0, blockLock}, 64'd0);
        sendGood(1);
        checkOutput("relockAfterSlip", {63'd0, blockLock}, 64'd1);

        // Locked: 15 bad in a window is tolerated, 16 in the next drops lock
        for (int i = 0; i < 64; i++)
            applyStimulus(1'b1, 1'b1, (i < 60 && i % 4 == 0) ? 2'b00 : goodHdr(), rndData());
        checkOutput("lockHeld15Bad", {63'd0, blockLock}, 64'd1);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 2'b11, rndData());
        checkOutput("lockLost16Bad", {63'd0, blockLock}, 64'd0);
        checkOutput("slipOnLoss", {63'd0, slip}, 64'd1);
        checkOutput("lossBlockFwd", {63'd0, outValid}, 64'd1);

        // Reset during holdoff, then full relock
        applyStimulus(1'b1, 1'b1, goodHdr(), rndData());
        sendGood(2);
        doReset();
        sendGood(63);
        checkOutput("noLockAfterRst63", {63'd0, blockLock}, 64'd0);
        sendGood(1);

        // Locked with valid toggling; a few bad headers stay under the limit
        for (int i = 0; i < 60; i++)
            applyStimulus(1'b1, (i % 2) == 0, (i % 13 == 0) ? 2'b11 : goodHdr(), rndData());
        doReset();
        checkOutput("rstLockedLock", {63'd0, blockLock}, 64'd0);
        checkOutput("rstLockedHdr", {62'd0, outHeader}, 64'd0);

        // Bad header on the final block of a clean window slips instead of locking
        sendGood(63);
        applyStimulus(1'b1, 1'b1, 2'b00, rndData());
        checkOutput("bad64NoLock", {63'd0, blockLock}, 64'd0);
        checkOutput("bad64Slip", {63'd0, slip}, 64'd1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++)
            applyStimulus(1'b1, $urandom_range(0, 3) != 0,
                          ($urandom_range(0, 39) == 0) ? 2'b11 : goodHdr(), rndData());

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
